lisnoc_wormhole_arbiter: RTL and testbench

LISNOC_WORMHOLE_ARBITER -- requirements
Module: lisnoc_wormhole_arbiter

---
 rtl/lisnoc_wormhole_arbiter_pkg.sv | 33 +++
 rtl/lisnoc_wormhole_arbiter_arb_rr.sv | 42 ++++
 rtl/lisnoc_wormhole_arbiter.sv | 130 +++++++++++++
 tb/tb_lisnoc_wormhole_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lisnoc_wormhole_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lisnoc_wormhole_arbiter_pkg
//
// Shared definitions for the LISNoC wormhole output arbiter slice:
//   - flit type encodings carried in the top bits of every flit
//   - arbiter FSM state encoding
//   - helper that tells whether a flit type closes a packet
// ---------------------------------------------------------------------------
package lisnoc_wormhole_arbiter_pkg;

    // Width of the flit type field that the encodings below occupy.
    localparam int FLIT_TYPE_W = 2;

    // Flit type encodings shared by every LISNoC block.
    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_PAYLOAD = 2'b00,
        FLIT_HEADER  = 2'b01,
        FLIT_LAST    = 2'b10,
        FLIT_SINGLE  = 2'b11
    } flit_type_e;

    // Arbiter states: IDLE picks a winner, LOCKED forwards its packet.
    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // A LAST or SINGLE flit releases the wormhole lock once transferred.
    function automatic logic isTailType(input logic [FLIT_TYPE_W-1:0] flitType);
        return (flitType == FLIT_LAST) || (flitType == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/lisnoc_wormhole_arbiter_arb_rr.sv
// ---------------------------------------------------------------------------
// lisnoc_arb_rr
//
// Purely combinational round-robin selector. Searches the request vector
// starting one position after ptr_i and wrapping modulo N; the first set
// request wins.
//
// Ports:
//   req_i  [N-1:0]      request vector
//   ptr_i  [PTR_W-1:0]  index of the most recently served requester
//   gnt_o  [N-1:0]      one-hot grant, all-zero when no request is set
// ---------------------------------------------------------------------------
module lisnoc_arb_rr
    import lisnoc_wormhole_arbiter_pkg::*;
#(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the ports in priority order ptr+1, ptr+2, ... and stop at the
    // first requester, so at most one grant bit is ever set.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PTR_W'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_wormhole_arbiter.sv
// ---------------------------------------------------------------------------
// lisnoc_wormhole_arbiter
//
// Wormhole arbiter for one output port of one virtual channel. In IDLE it
// picks the next requester round-robin; in LOCKED it passes the granted
// input straight through to the output until a LAST or SINGLE flit has been
// transferred, then drops back to IDLE for one bubble cycle.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   in_flit    ports*flit_width flattened input flits, port i at
//              [i*flit_width +: flit_width]; type field in the top bits
//   in_valid   per-port flit valid
//   in_ready   per-port flit accepted (only the granted port can be ready)
//   out_flit   flit toward the shared output port
//   out_valid  output flit valid
//   out_ready  downstream accepts the flit
//   gnt_o      one-hot current grant, all-zero when idle
// ---------------------------------------------------------------------------
module lisnoc_wormhole_arbiter
    import lisnoc_wormhole_arbiter_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ports           = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ports*(flit_data_width+flit_type_width)-1:0] in_flit,
    input  logic [ports-1:0]              in_valid,
    output logic [ports-1:0]              in_ready,
    output logic [flit_data_width+flit_type_width-1:0] out_flit,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ports-1:0]              gnt_o
);

    localparam int flit_width = flit_data_width + flit_type_width;
    localparam int PTR_W      = (ports > 1) ? $clog2(ports) : 1;

    arb_state_e        state_q, state_d;
    logic [ports-1:0]  gnt_q, gnt_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic [ports-1:0]  arbGnt;
    logic [PTR_W-1:0]  gntIdx;
    logic [FLIT_TYPE_W-1:0] outType;

    lisnoc_arb_rr #(
        .N     (ports),
        .PTR_W (PTR_W)
    ) u_arb_rr (
        .req_i (in_valid),
        .ptr_i (ptr_q),
        .gnt_o (arbGnt)
    );

    // Binary index of the held grant; becomes the new round-robin pointer
    // when the packet finishes.
    always_comb begin
        gntIdx = '0;
        for (int i = 0; i < ports; i++) begin
            if (gnt_q[i]) begin
                gntIdx = PTR_W'(i);
            end
        end
    end

    // The type field sits in the top bits of the flit.
    assign outType = out_flit[flit_width-1 -: FLIT_TYPE_W];

    // Next-state and datapath. The grant register is one-hot or zero, so
    // OR-ing the gated input slices forms the output mux.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        out_flit  = '0;
        out_valid = 1'b0;
        in_ready  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (|in_valid) begin
                    state_d = ARB_LOCKED;
                    gnt_d   = arbGnt;
                end
            end

            ARB_LOCKED: begin
                for (int i = 0; i < ports; i++) begin
                    if (gnt_q[i]) begin
                        out_flit    = out_flit | in_flit[i*flit_width +: flit_width];
                        out_valid   = out_valid | in_valid[i];
                        in_ready[i] = out_ready;
                    end
                end
                // Only a transferred tail flit releases the wormhole lock.
                if (out_valid && out_ready && isTailType(outType)) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                    ptr_d   = gntIdx;
                end
            end

            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // State registers. After reset the pointer sits on the last port so
    // port 0 has highest priority for the first arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_W'(ports - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: tb/tb_lisnoc_wormhole_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lisnoc_wormhole_arbiter
//
// Directed bench for the wormhole arbiter with 5 ports and 34-bit flits
// ({type, data}). Inputs change on the falling edge; outputs are checked
// 1ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_lisnoc_wormhole_arbiter;

    localparam int DW    = 32;
    localparam int TW    = 2;
    localparam int FW    = DW + TW;
    localparam int PORTS = 5;

    localparam logic [1:0] T_PAYLOAD = 2'b00;
    localparam logic [1:0] T_HEADER  = 2'b01;
    localparam logic [1:0] T_LAST    = 2'b10;
    localparam logic [1:0] T_SINGLE  = 2'b11;

    logic                  clk;
    logic                  rst;
    logic [PORTS*FW-1:0]   inFlit;
    logic [PORTS-1:0]      inValid;
    logic [PORTS-1:0]      inReady;
    logic [FW-1:0]         outFlit;
    logic                  outValid;
    logic                  outReady;
    logic [PORTS-1:0]      gnt;

    int compareCount;
    int failCount;

    lisnoc_wormhole_arbiter #(
        .flit_data_width (DW),
        .flit_type_width (TW),
        .ports           (PORTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (inFlit),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .out_flit  (outFlit),
        .out_valid (outValid),
        .out_ready (outReady),
        .gnt_o     (gnt)
    );

    // Free-running 10ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [FW-1:0] mkFlit(input logic [1:0] t, input logic [DW-1:0] d);
        return {t, d};
    endfunction

    // Place one flit on one input port.
    task automatic setPort(input int p, input logic [FW-1:0] f);
        inFlit[p*FW +: FW] = f;
    endtask

    // Move to the next falling edge, apply valids/ready, let logic settle.
    task automatic applyStimulus(input logic [PORTS-1:0] valid, input logic ready);
        @(negedge clk);
        inValid  = valid;
        outReady = ready;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Checks the whole handshake picture of one cycle.
    task automatic checkCycle(input string tag, input logic [PORTS-1:0] expGnt,
                              input logic expValid, input logic [PORTS-1:0] expReady);
        checkOutput({tag, "_gnt"},   64'(gnt),      64'(expGnt));
        checkOutput({tag, "_valid"}, 64'(outValid), 64'(expValid));
        checkOutput({tag, "_ready"}, 64'(inReady),  64'(expReady));
    endtask

    logic [1:0]    pktType [4];
    logic [FW-1:0] heldFlit;

    initial begin
        compareCount = 0;
        failCount    = 0;
        rst      = 1'b0;
        inFlit   = '0;
        inValid  = '0;
        outReady = 1'b0;
        pktType  = '{T_HEADER, T_PAYLOAD, T_PAYLOAD, T_LAST};

        // Reset state.
        applyStimulus(5'b00000, 1'b0);
        checkCycle("reset", 5'b00000, 1'b0, 5'b00000);
        @(negedge clk);
        rst = 1'b1;

        // Port 0 single flit competing with port 4; port 0 wins after reset.
        setPort(0, mkFlit(T_SINGLE, 32'hA000_0000));
        setPort(4, mkFlit(T_SINGLE, 32'hA000_0004));
        applyStimulus(5'b10001, 1'b1);
        checkCycle("t1_idle", 5'b00000, 1'b0, 5'b00000);
        applyStimulus(5'b10001, 1'b1);
        checkCycle("t1_p0", 5'b00001, 1'b1, 5'b00001);
        checkOutput("t1_p0_flit", 64'(outFlit), 64'(mkFlit(T_SINGLE, 32'hA000_0000)));
        applyStimulus(5'b10000, 1'b1);
        checkCycle("t1_bubble", 5'b00000, 1'b0, 5'b00000);
        applyStimulus(5'b10000, 1'b1);
        checkCycle("t1_p4", 5'b10000, 1'b1, 5'b10000);
        checkOutput("t1_p4_flit", 64'(outFlit), 64'(mkFlit(T_SINGLE, 32'hA000_0004)));

        // Port 2 four-flit packet with port 3 waiting throughout (ptr = 4).
        setPort(2, mkFlit(T_HEADER, 32'hB200_0000));
        setPort(3, mkFlit(T_SINGLE, 32'hB300_0000));
        applyStimulus(5'b01100, 1'b1);
        checkCycle("t2_idle", 5'b00000, 1'b0, 5'b00000);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            setPort(2, mkFlit(pktType[k], 32'hB200_0000 + 32'(k)));
            inValid  = 5'b01100;
            outReady = 1'b1;
            #1;
            checkCycle($sformatf("t2_flit%0d", k), 5'b00100, 1'b1, 5'b00100);
            checkOutput($sformatf("t2_flit%0d_data", k), 64'(outFlit),
                        64'(mkFlit(pktType[k], 32'hB200_0000 + 32'(k))));
        end
        applyStimulus(5'b01000, 1'b1);
        checkCycle("t2_bubble", 5'b00000, 1'b0, 5'b00000);
        applyStimulus(5'b01000, 1'b1);
        checkCycle("t2_p3", 5'b01000, 1'b1, 5'b01000);

        // Port 1 sole requester (ptr = 3), then drops valid mid-packet.
        setPort(1, mkFlit(T_HEADER, 32'hC100_0000));
        applyStimulus(5'b00010, 1'b1);
        checkCycle("t4_idle", 5'b00000, 1'b0, 5'b00000);
        applyStimulus(5'b00010, 1'b1);
        checkCycle("t4_hdr", 5'b00010, 1'b1, 5'b00010);
        setPort(4, mkFlit(T_SINGLE, 32'hC400_0000));
        for (int k = 0; k < 3; k++) begin
            applyStimulus(5'b10000, 1'b1);
            checkCycle($sformatf("t4_gap%0d", k), 5'b00010, 1'b0, 5'b00010);
        end

        // Downstream stalls for 4 cycles with port 1 payload pending.
        heldFlit = mkFlit(T_PAYLOAD, 32'hC100_0001);
        setPort(1, heldFlit);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(5'b10010, 1'b0);
            checkCycle($sformatf("t5_stall%0d", k), 5'b00010, 1'b1, 5'b00000);
            checkOutput($sformatf("t5_stall%0d_flit", k), 64'(outFlit), 64'(heldFlit));
        end

        // Reset mid-packet drops the lock immediately.
        for (int p = 0; p < PORTS; p++) begin
            setPort(p, mkFlit(T_SINGLE, 32'hD000_0000 + 32'(p)));
        end
        @(negedge clk);
        rst      = 1'b0;
        inValid  = 5'b11111;
        outReady = 1'b1;
        #1;
        checkCycle("t6_rst", 5'b00000, 1'b0, 5'b00000);
        @(negedge clk);
        checkCycle("t6_rst_held", 5'b00000, 1'b0, 5'b00000);
        rst = 1'b1;
        #1;
        checkCycle("t6_release", 5'b00000, 1'b0, 5'b00000);

        // All ports streaming single flits: 0,1,2,3,4,0 with a bubble between.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(5'b11111, 1'b1);
            checkCycle($sformatf("t3_gnt%0d", k), 5'(1 << (k % PORTS)), 1'b1,
                       5'(1 << (k % PORTS)));
            checkOutput($sformatf("t3_gnt%0d_flit", k), 64'(outFlit),
                        64'(mkFlit(T_SINGLE, 32'hD000_0000 + 32'(k % PORTS))));
            applyStimulus(5'b11111, 1'b1);
            checkCycle($sformatf("t3_bubble%0d", k), 5'b00000, 1'b0, 5'b00000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
